vend_change_ctrl: RTL and testbench

- Sequencing controller for the vending machine datapath. It owns the customer balance register and the coin-return wait timer.
- It accepts coins, qualifies item purchases, and on timeout or a return request dispenses change one coin at a time, greedily, over a valid/ready handshake to the coin hopper.
- It sits between the front-panel input decode and the item/coin dispensers.

---
 rtl/vend_change_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_vend_change_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_change_ctrl.sv
// vend_change_ctrl: vending machine sequencing controller.
// Owns the customer balance and the coin-return wait timer. It accepts coins,
// qualifies purchases, and pays change greedily (1000, 500, 100) one coin at a
// time over a valid/ready handshake to the coin hopper.
//
// Optional build macro: VEND_SALES_STATS_EN
//   When defined, adds o_sales_total[31:0], a wrapping accumulator of the
//   price of every dispensed item. When undefined, neither the port nor the
//   accumulator exists.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | zero balance, waiting for the first coin
// ACTIVE  | balance held, timer running, coins and selects accepted
// RETURN  | paying out change, one coin per hopper handshake

module vend_change_ctrl #(
    parameter int unsigned WAIT_CYCLES = 100,
    parameter int unsigned BAL_W       = 16,
    parameter int unsigned MAX_BALANCE = 9900
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       i_input_coin,
    input  logic [3:0]       i_select_item,
    input  logic             i_trigger_return,
    input  logic             i_return_ready,
    output logic [3:0]       o_available_item,
    output logic [3:0]       o_output_item,
    output logic             o_coin_reject,
    output logic [2:0]       o_return_coin,
    output logic             o_return_valid,
    output logic [BAL_W-1:0] o_balance,
    output logic [31:0]      o_wait_time,
    output logic             o_busy
`ifdef VEND_SALES_STATS_EN
    ,
    output logic [31:0]      o_sales_total
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RETURN = 2'd2
    } state_t;

    localparam logic [BAL_W-1:0] VAL_100   = BAL_W'(100);
    localparam logic [BAL_W-1:0] VAL_400   = BAL_W'(400);
    localparam logic [BAL_W-1:0] VAL_500   = BAL_W'(500);
    localparam logic [BAL_W-1:0] VAL_1000  = BAL_W'(1000);
    localparam logic [BAL_W-1:0] VAL_2000  = BAL_W'(2000);
    localparam logic [BAL_W:0]   MAX_EXT   = (BAL_W+1)'(MAX_BALANCE);
    localparam logic [31:0]      WAIT_LOAD = 32'(WAIT_CYCLES);

    // Value of a one-hot return/insert coin; anything else is worth nothing.
    function automatic logic [BAL_W-1:0] coin_value(input logic [2:0] coin);
        logic [BAL_W-1:0] v;
        case (coin)
            3'b001:  v = VAL_100;
            3'b010:  v = VAL_500;
            3'b100:  v = VAL_1000;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Price of a one-hot item select; multi-hot or zero selects cost nothing.
    function automatic logic [BAL_W-1:0] item_price(input logic [3:0] item);
        logic [BAL_W-1:0] v;
        case (item)
            4'b0001: v = VAL_400;
            4'b0010: v = VAL_500;
            4'b0100: v = VAL_1000;
            4'b1000: v = VAL_2000;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Largest coin not exceeding the balance; zero when nothing is owed.
    function automatic logic [2:0] greedy_coin(input logic [BAL_W-1:0] bal);
        logic [2:0] c;
        if (bal >= VAL_1000) begin
            c = 3'b100;
        end else if (bal >= VAL_500) begin
            c = 3'b010;
        end else if (bal != '0) begin
            c = 3'b001;
        end else begin
            c = 3'b000;
        end
        return c;
    endfunction

    state_t           state_q,     state_d;
    logic [BAL_W-1:0] bal_q,       bal_d;
    logic [31:0]      timer_q,     timer_d;
    logic [3:0]       item_q,      item_d;
    logic             reject_q,    reject_d;
    logic [2:0]       ret_coin_q,  ret_coin_d;
    logic             ret_valid_q, ret_valid_d;
`ifdef VEND_SALES_STATS_EN
    logic [31:0]      sales_q,     sales_d;
`endif

    logic             coin_ev;
    logic             sel_ev;
    logic [BAL_W-1:0] coin_val;
    logic [BAL_W-1:0] price_val;
    logic             buy_ok;
    logic [BAL_W-1:0] spend;
    logic [BAL_W:0]   after_buy;
    logic [BAL_W:0]   with_coin;
    logic             coin_ok;
    logic             active;

    // Event decode and the purchase/overflow arithmetic shared by IDLE and ACTIVE.
    always_comb begin
        coin_val  = coin_value(i_input_coin);
        price_val = item_price(i_select_item);
        coin_ev   = (coin_val != '0);
        sel_ev    = (price_val != '0);
        // Purchase is judged against the balance before any coin in this cycle.
        buy_ok    = (state_q == ST_ACTIVE) && sel_ev && (bal_q >= price_val);
        spend     = buy_ok ? price_val : '0;
        // One extra bit so old + coin cannot wrap before the limit compare;
        // buy_ok guarantees the subtraction never goes negative.
        after_buy = {1'b0, bal_q} - {1'b0, spend};
        with_coin = after_buy + {1'b0, coin_val};
        coin_ok   = coin_ev && (with_coin <= MAX_EXT);
    end

    // Next-state, balance, timer and registered-output computation.
    always_comb begin
        logic [BAL_W-1:0] bal_nx;
        state_d     = state_q;
        bal_d       = bal_q;
        timer_d     = timer_q;
        item_d      = '0;
        reject_d    = 1'b0;
        ret_coin_d  = ret_coin_q;
        ret_valid_d = ret_valid_q;
        bal_nx      = bal_q;
`ifdef VEND_SALES_STATS_EN
        sales_d     = sales_q;
`endif

        case (state_q)
            ST_IDLE: begin
                ret_coin_d  = '0;
                ret_valid_d = 1'b0;
                timer_d     = '0;
                if (coin_ev) begin
                    bal_d   = with_coin[BAL_W-1:0];
                    timer_d = WAIT_LOAD;
                    state_d = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                bal_nx   = coin_ok ? with_coin[BAL_W-1:0] : after_buy[BAL_W-1:0];
                bal_d    = bal_nx;
                reject_d = coin_ev && !coin_ok;
                item_d   = buy_ok ? i_select_item : 4'b0000;
`ifdef VEND_SALES_STATS_EN
                sales_d  = sales_q + 32'(spend);
`endif
                // A return request still lets a same-cycle purchase finish;
                // the timer expires on the step that would take it from 1 to 0.
                if (i_trigger_return ||
                    (!buy_ok && !coin_ok && (timer_q <= 32'd1))) begin
                    timer_d = '0;
                    if (bal_nx != '0) begin
                        state_d     = ST_RETURN;
                        ret_valid_d = 1'b1;
                        ret_coin_d  = greedy_coin(bal_nx);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (buy_ok || coin_ok) begin
                    timer_d = WAIT_LOAD;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end

            ST_RETURN: begin
                reject_d = coin_ev;
                timer_d  = '0;
                // Without ready the presented coin and valid simply hold.
                if (ret_valid_q && i_return_ready) begin
                    bal_nx = bal_q - coin_value(ret_coin_q);
                    bal_d  = bal_nx;
                    if (bal_nx == '0) begin
                        state_d     = ST_IDLE;
                        ret_valid_d = 1'b0;
                        ret_coin_d  = '0;
                    end else begin
                        ret_valid_d = 1'b1;
                        ret_coin_d  = greedy_coin(bal_nx);
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                bal_d       = '0;
                timer_d     = '0;
                ret_coin_d  = '0;
                ret_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any coin being presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bal_q       <= '0;
            timer_q     <= '0;
            item_q      <= '0;
            reject_q    <= 1'b0;
            ret_coin_q  <= '0;
            ret_valid_q <= 1'b0;
`ifdef VEND_SALES_STATS_EN
            sales_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bal_q       <= bal_d;
            timer_q     <= timer_d;
            item_q      <= item_d;
            reject_q    <= reject_d;
            ret_coin_q  <= ret_coin_d;
            ret_valid_q <= ret_valid_d;
`ifdef VEND_SALES_STATS_EN
            sales_q     <= sales_d;
`endif
        end
    end

    // Affordability flags are only meaningful while a purchase can happen.
    always_comb begin
        active              = (state_q == ST_ACTIVE);
        o_available_item[0] = active && (bal_q >= VAL_400);
        o_available_item[1] = active && (bal_q >= VAL_500);
        o_available_item[2] = active && (bal_q >= VAL_1000);
        o_available_item[3] = active && (bal_q >= VAL_2000);
    end

    assign o_output_item  = item_q;
    assign o_coin_reject  = reject_q;
    assign o_return_coin  = ret_coin_q;
    assign o_return_valid = ret_valid_q;
    assign o_balance      = bal_q;
    assign o_wait_time    = timer_q;
    assign o_busy         = (state_q == ST_RETURN);
`ifdef VEND_SALES_STATS_EN
    assign o_sales_total  = sales_q;
`endif

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Bench for vend_change_ctrl: directed scenarios plus randomized traffic,
// scored against a transaction-level model of balance, timer and change.
module tb_vend_change_ctrl;

    localparam int WAIT = 100;
    localparam int MAXB = 9900;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  i_input_coin = '0;
    logic [3:0]  i_select_item = '0;
    logic        i_trigger_return = 1'b0;
    logic        i_return_ready = 1'b0;
    logic [3:0]  o_available_item;
    logic [3:0]  o_output_item;
    logic        o_coin_reject;
    logic [2:0]  o_return_coin;
    logic        o_return_valid;
    logic [15:0] o_balance;
    logic [31:0] o_wait_time;
    logic        o_busy;
`ifdef VEND_SALES_STATS_EN
    logic [31:0] o_sales_total;
`endif

    vend_change_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .i_trigger_return (i_trigger_return),
        .i_return_ready   (i_return_ready),
        .o_available_item (o_available_item),
        .o_output_item    (o_output_item),
        .o_coin_reject    (o_coin_reject),
        .o_return_coin    (o_return_coin),
        .o_return_valid   (o_return_valid),
        .o_balance        (o_balance),
        .o_wait_time      (o_wait_time),
        .o_busy           (o_busy)
`ifdef VEND_SALES_STATS_EN
        ,
        .o_sales_total    (o_sales_total)
`endif
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (edge %0d)", nm, act, req, edge_n);
        end
    endtask

    // Expected events, tagged with the edge after which they must be visible.
    typedef struct {
        int at;
        int val;
    } ev_t;
    ev_t q_item[$];
    ev_t q_rej[$];
    ev_t q_ret[$];

    // Reference model: 0 = no credit, 1 = shopping, 2 = paying change.
    int m_mode  = 0;
    int m_bal   = 0;
    int m_timer = 0;

    function automatic int coin_amt(input logic [2:0] c);
        case (c)
            3'b001:  return 100;
            3'b010:  return 500;
            3'b100:  return 1000;
            default: return 0;
        endcase
    endfunction

    function automatic int price_amt(input logic [3:0] s);
        case (s)
            4'b0001: return 400;
            4'b0010: return 500;
            4'b0100: return 1000;
            4'b1000: return 2000;
            default: return 0;
        endcase
    endfunction

    function automatic int greedy_amt(input int b);
        if (b >= 1000) return 1000;
        if (b >= 500) return 500;
        return 100;
    endfunction

    function automatic int amt_code(input int a);
        if (a == 1000) return 4;
        if (a == 500) return 2;
        if (a == 100) return 1;
        return 0;
    endfunction

    task automatic model_step(input logic [2:0] c, input logic [3:0] s,
                              input logic t, input logic r);
        int cv;
        int pv;
        int nb;
        int g;
        bit buy;
        bit cok;
        cv = coin_amt(c);
        pv = price_amt(s);
        case (m_mode)
            0: begin
                if (cv > 0) begin
                    m_bal   = m_bal + cv;
                    m_timer = WAIT;
                    m_mode  = 1;
                end
            end
            1: begin
                buy = (pv > 0) && (m_bal >= pv);
                nb  = buy ? m_bal - pv : m_bal;
                cok = (cv > 0) && (nb + cv <= MAXB);
                if (cv > 0 && !cok) q_rej.push_back('{edge_n + 1, 1});
                if (buy) q_item.push_back('{edge_n + 1, int'(s)});
                if (cok) nb = nb + cv;
                m_bal = nb;
                if (t || (!buy && !cok && m_timer <= 1)) begin
                    m_timer = 0;
                    m_mode  = (m_bal > 0) ? 2 : 0;
                end else if (buy || cok) begin
                    m_timer = WAIT;
                end else begin
                    m_timer = m_timer - 1;
                end
            end
            default: begin
                if (cv > 0) q_rej.push_back('{edge_n + 1, 1});
                if (r) begin
                    g = greedy_amt(m_bal);
                    q_ret.push_back('{edge_n + 1, amt_code(g)});
                    m_bal = m_bal - g;
                    if (m_bal == 0) m_mode = 0;
                end
            end
        endcase
    endtask

    // One clock of stimulus; the model advances in step with the DUT edge.
    task automatic drive(input logic [2:0] c, input logic [3:0] s,
                         input logic t, input logic r);
        @(posedge clk);
        #2;
        i_input_coin     = c;
        i_select_item    = s;
        i_trigger_return = t;
        i_return_ready   = r;
        model_step(c, s, t, r);
    endtask

    task automatic idle(input int n, input logic r);
        for (int k = 0; k < n; k++) drive(3'b000, 4'b0000, 1'b0, r);
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (m_mode == 2 && k < 400) begin
            drive(3'b000, 4'b0000, 1'b0, 1'b1);
            k++;
        end
        check({nm, "_drain_bound"}, int'(m_mode == 2), 0);
        idle(2, 1'b1);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_bal"},   int'(o_balance), 0);
        check({nm, "_timer"}, int'(o_wait_time), 0);
        check({nm, "_valid"}, int'(o_return_valid), 0);
        check({nm, "_coin"},  int'(o_return_coin), 0);
        check({nm, "_busy"},  int'(o_busy), 0);
        check({nm, "_avail"}, int'(o_available_item), 0);
        check({nm, "_item"},  int'(o_output_item), 0);
        check({nm, "_rej"},   int'(o_coin_reject), 0);
    endtask

    // Monitor: compares DUT state with the model and pops expected events.
    int  prev_valid = 0;
    int  prev_coin  = 0;
    initial begin
        int exp_av;
        int hs;
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_valid = 0;
                prev_coin  = 0;
            end else begin
                check("balance", int'(o_balance), m_bal);
                check("wait_time", int'(o_wait_time), m_timer);
                check("busy", int'(o_busy), int'(m_mode == 2));
                check("ret_valid", int'(o_return_valid), int'(m_mode == 2));
                if (m_mode == 2) check("ret_coin_shown", int'(o_return_coin), amt_code(greedy_amt(m_bal)));
                exp_av = 0;
                if (m_mode == 1) begin
                    if (m_bal >= 400)  exp_av |= 1;
                    if (m_bal >= 500)  exp_av |= 2;
                    if (m_bal >= 1000) exp_av |= 4;
                    if (m_bal >= 2000) exp_av |= 8;
                end
                check("available", int'(o_available_item), exp_av);

                if (q_item.size() > 0 && q_item[0].at == edge_n) begin
                    e = q_item.pop_front();
                    check("item_pulse", int'(o_output_item), e.val);
                end else begin
                    check("item_quiet", int'(o_output_item), 0);
                end

                if (q_rej.size() > 0 && q_rej[0].at == edge_n) begin
                    e = q_rej.pop_front();
                    check("reject_pulse", int'(o_coin_reject), e.val);
                end else begin
                    check("reject_quiet", int'(o_coin_reject), 0);
                end

                hs = int'(prev_valid != 0 && i_return_ready);
                if (q_ret.size() > 0 && q_ret[0].at == edge_n) begin
                    e = q_ret.pop_front();
                    check("ret_handshake", hs, 1);
                    check("ret_coin", prev_coin, e.val);
                end else begin
                    check("ret_no_handshake", hs, 0);
                end
                prev_valid = int'(o_return_valid);
                prev_coin  = int'(o_return_coin);
            end
        end
    end

    function automatic logic [2:0] rand_coin(input int pct);
        int r;
        logic [2:0] c;
        r = int'($urandom_range(0, 99));
        c = 3'b000;
        if (r < pct) c = 3'b001 << $urandom_range(0, 2);
        else if (r < pct + 2) c = 3'($urandom_range(0, 7));
        return c;
    endfunction

    function automatic logic [3:0] rand_sel(input int pct);
        int r;
        logic [3:0] s;
        r = int'($urandom_range(0, 99));
        s = 4'b0000;
        if (r < pct) s = 4'b0001 << $urandom_range(0, 3);
        else if (r < pct + 2) s = 4'($urandom_range(0, 15));
        return s;
    endfunction

    initial begin
        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Purchase with change, then timeout payout of 500.
        drive(3'b100, 4'b0000, 1'b0, 1'b0);
        drive(3'b000, 4'b0010, 1'b0, 1'b0);
        idle(100, 1'b0);
        drain("s1");

        // Unaffordable select ignored, return request pays 500 then 100.
        drive(3'b010, 4'b0000, 1'b0, 1'b1);
        drive(3'b001, 4'b0000, 1'b0, 1'b1);
        drive(3'b000, 4'b1000, 1'b0, 1'b1);
        idle(3, 1'b1);
        drive(3'b000, 4'b0000, 1'b1, 1'b1);
        drain("s2");

        // 1600 with hopper stalled, then released.
        drive(3'b100, 4'b0000, 1'b0, 1'b0);
        drive(3'b010, 4'b0000, 1'b0, 1'b0);
        drive(3'b001, 4'b0000, 1'b0, 1'b0);
        drive(3'b000, 4'b0000, 1'b1, 1'b0);
        idle(5, 1'b0);
        drain("s3");

        // Balance ceiling.
        for (int k = 0; k < 9; k++) drive(3'b100, 4'b0000, 1'b0, 1'b0);
        drive(3'b010, 4'b0000, 1'b0, 1'b0);
        drive(3'b010, 4'b0000, 1'b0, 1'b0);
        drive(3'b001, 4'b0000, 1'b0, 1'b0);
        drive(3'b000, 4'b0000, 1'b1, 1'b1);
        drain("s4");

        // Coin and select in the same cycle.
        for (int k = 0; k < 3; k++) drive(3'b001, 4'b0000, 1'b0, 1'b0);
        drive(3'b010, 4'b0001, 1'b0, 1'b0);
        drive(3'b001, 4'b0001, 1'b0, 1'b0);
        drive(3'b000, 4'b0100, 1'b1, 1'b0);
        drain("s5");

        // Asynchronous reset while a coin is presented.
        drive(3'b100, 4'b0000, 1'b0, 1'b0);
        drive(3'b100, 4'b0000, 1'b0, 1'b0);
        drive(3'b000, 4'b0000, 1'b1, 1'b0);
        idle(2, 1'b0);
        @(posedge clk);
        #3;
        check("pre_reset_valid", int'(o_return_valid), 1);
        i_input_coin = '0; i_select_item = '0; i_trigger_return = 1'b0; i_return_ready = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        m_mode = 0; m_bal = 0; m_timer = 0;
        q_item.delete(); q_rej.delete(); q_ret.delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        drive(3'b000, 4'b0010, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Randomized traffic: busy phase, then sparse phase so timeouts occur.
        for (int k = 0; k < 1500; k++)
            drive(rand_coin(20), rand_sel(15), 1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 1500; k++)
            drive(rand_coin(2), rand_sel(2), 1'($urandom_range(0, 199) < 1), 1'($urandom_range(0, 2) != 0));
        if (m_mode == 1) drive(3'b000, 4'b0000, 1'b1, 1'b1);
        drain("rand");

        check("q_item_empty", q_item.size(), 0);
        check("q_rej_empty",  q_rej.size(), 0);
        check("q_ret_empty",  q_ret.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
